// File: rtl/elevator_dispatch_scheduler_if.sv
// Handshake bundle between the dispatch scheduler and its environment.
// The master side drives call buttons and move_done. The slave (the scheduler) drives lamps, floor, door and move requests.
interface elevator_dispatch_scheduler_if;
  logic [2:0] elevator_floor_button_pressed;
  logic [3:0] floor_button_pressed;
  logic       move_done;
  logic [2:0] floor;
  logic       door;
  logic       move_req;
  logic       move_up;
  logic [2:0] elevator_button_out;
  logic [3:0] floor_button_out;

  modport master (
    output elevator_floor_button_pressed,
    output floor_button_pressed,
    output move_done,
    input  floor,
    input  door,
    input  move_req,
    input  move_up,
    input  elevator_button_out,
    input  floor_button_out
  );

  modport slave (
    input  elevator_floor_button_pressed,
    input  floor_button_pressed,
    input  move_done,
    output floor,
    output door,
    output move_req,
    output move_up,
    output elevator_button_out,
    output floor_button_out
  );
endinterface

// File: rtl/elevator_dispatch_scheduler.sv
// Three-floor elevator scheduler: latches car/hall calls, picks a direction, and requests one-floor moves.
// Door timing and call clearing are handled inside the module. Floor vectors are one-hot: bit2 = floor 1, bit1 = floor 2, bit0 = floor 3.
module elevator_dispatch_scheduler #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  elevator_dispatch_scheduler_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] floor_reg, floor_next;
  logic       dir_up_reg, dir_up_next;
  logic [2:0] car_reg, car_next;
  logic [3:0] hall_reg, hall_next;
  logic [3:0] hall_mask_reg, hall_mask_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       door_reg, move_req_reg, move_up_reg;

  logic       at_f1, at_f2, at_f3;
  logic       req_f1, req_f2, req_f3;
  logic       req_above, req_below, req_beyond, req_behind;
  logic [3:0] hall_up_bit, hall_dn_bit, hall_dir_bit, hall_opp_bit;
  logic       car_here, hall_dir_here, hall_opp_here, stop_here;
  logic [2:0] car_block, car_clr;
  logic [3:0] hall_block, hall_clr;
  logic       door_repress;

  genvar gi;

  assign at_f1 = floor_reg[2];
  assign at_f2 = floor_reg[1];
  assign at_f3 = floor_reg[0];

  assign req_f1 = car_reg[2] | hall_reg[3];
  assign req_f2 = car_reg[1] | hall_reg[1] | hall_reg[2];
  assign req_f3 = car_reg[0] | hall_reg[0];

  assign req_above = (at_f1 & (req_f2 | req_f3)) | (at_f2 & req_f3);
  assign req_below = (at_f3 & (req_f1 | req_f2)) | (at_f2 & req_f1);

  assign req_beyond = dir_up_reg ? req_above : req_below;
  assign req_behind = dir_up_reg ? req_below : req_above;

  // Hall-button positions that belong to the current floor, per direction.
  assign hall_up_bit = at_f1 ? 4'b1000 : (at_f2 ? 4'b0010 : 4'b0000);
  assign hall_dn_bit = at_f3 ? 4'b0001 : (at_f2 ? 4'b0100 : 4'b0000);

  assign hall_dir_bit = dir_up_reg ? hall_up_bit : hall_dn_bit;
  assign hall_opp_bit = dir_up_reg ? hall_dn_bit : hall_up_bit;

  assign car_here      = |(car_reg & floor_reg);
  assign hall_dir_here = |(hall_reg & hall_dir_bit);
  assign hall_opp_here = |(hall_reg & hall_opp_bit);
  assign stop_here     = car_here | hall_dir_here | (hall_opp_here & ~req_beyond);

  // While the door is open, presses for the calls just serviced only hold the door.
  assign car_block  = (state_reg == DOOR_OPEN) ? floor_reg     : 3'b000;
  assign hall_block = (state_reg == DOOR_OPEN) ? hall_mask_reg : 4'b0000;

  assign door_repress = (|(bus.elevator_floor_button_pressed & car_block))
                      | (|(bus.floor_button_pressed & hall_block));

  always_comb begin
    state_next     = state_reg;
    floor_next     = floor_reg;
    dir_up_next    = dir_up_reg;
    hall_mask_next = hall_mask_reg;
    cnt_next       = cnt_reg;
    car_clr        = 3'b000;
    hall_clr       = 4'b0000;

    case (state_reg)
      IDLE: begin
        if (stop_here) begin
          state_next = DOOR_OPEN;
          cnt_next   = CNT_LOAD;
          car_clr    = floor_reg;
          hall_clr   = hall_dir_bit | (req_beyond ? 4'b0000 : hall_opp_bit);
          hall_mask_next = hall_clr;
          if (!req_beyond) begin
            dir_up_next = ~dir_up_reg;
          end
        end else if (req_beyond) begin
          state_next = dir_up_reg ? MOVE_UP : MOVE_DOWN;
        end else if (req_behind) begin
          dir_up_next = ~dir_up_reg;
          state_next  = dir_up_reg ? MOVE_DOWN : MOVE_UP;
        end
      end

      MOVE_UP: begin
        if (bus.move_done) begin
          floor_next = at_f3 ? floor_reg : {1'b0, floor_reg[2:1]};
          state_next = IDLE;
        end
      end

      MOVE_DOWN: begin
        if (bus.move_done) begin
          floor_next = at_f1 ? floor_reg : {floor_reg[1:0], 1'b0};
          state_next = IDLE;
        end
      end

      DOOR_OPEN: begin
        if (door_repress) begin
          cnt_next = CNT_LOAD;
        end else if (cnt_reg == 4'd0) begin
          state_next     = IDLE;
          hall_mask_next = 4'b0000;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // End floors pin the direction so the register never points off the shaft.
    if (floor_next[2]) begin
      dir_up_next = 1'b1;
    end else if (floor_next[0]) begin
      dir_up_next = 1'b0;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_car
      assign car_next[gi] = (car_reg[gi] | (bus.elevator_floor_button_pressed[gi] & ~car_block[gi]))
                          & ~car_clr[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_hall
      assign hall_next[gi] = (hall_reg[gi] | (bus.floor_button_pressed[gi] & ~hall_block[gi]))
                           & ~hall_clr[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      floor_reg     <= 3'b100;
      dir_up_reg    <= 1'b1;
      car_reg       <= 3'b000;
      hall_reg      <= 4'b0000;
      hall_mask_reg <= 4'b0000;
      cnt_reg       <= 4'd0;
      door_reg      <= 1'b0;
      move_req_reg  <= 1'b0;
      move_up_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      floor_reg     <= floor_next;
      dir_up_reg    <= dir_up_next;
      car_reg       <= car_next;
      hall_reg      <= hall_next;
      hall_mask_reg <= hall_mask_next;
      cnt_reg       <= cnt_next;
      door_reg      <= (state_next == DOOR_OPEN);
      move_req_reg  <= (state_next == MOVE_UP) || (state_next == MOVE_DOWN);
      move_up_reg   <= (state_next == MOVE_UP);
    end
  end

  assign bus.floor               = floor_reg;
  assign bus.door                = door_reg;
  assign bus.move_req            = move_req_reg;
  assign bus.move_up             = move_up_reg;
  assign bus.elevator_button_out = car_reg;
  assign bus.floor_button_out    = hall_reg;

  a_door_move_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(door_reg && move_req_reg));

  a_floor_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot(floor_reg));

endmodule

// File: tb/tb_elevator_dispatch_scheduler.sv
// Directed bench for elevator_dispatch_scheduler: a per-cycle vector table followed by multi-cycle scenarios.
module tb_elevator_dispatch_scheduler;

  logic clk;
  logic rst_n;

  elevator_dispatch_scheduler_if bus_if ();

  elevator_dispatch_scheduler #(.DOOR_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Inputs applied before an edge and outputs expected just after it.
  typedef struct packed {
    logic [2:0] car;
    logic [3:0] hall;
    logic       md;
    logic [2:0] exp_floor;
    logic       exp_door;
    logic       exp_mreq;
    logic       exp_mup;
    logic [2:0] exp_car;
    logic [3:0] exp_hall;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic logic [12:0] outs();
    return {bus_if.floor, bus_if.door, bus_if.move_req, bus_if.move_up,
            bus_if.elevator_button_out, bus_if.floor_button_out};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] car, input logic [3:0] hall, input logic md);
    @(negedge clk);
    bus_if.elevator_floor_button_pressed = car;
    bus_if.floor_button_pressed          = hall;
    bus_if.move_done                     = md;
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive samples with door high, starting at the current sample.
  task automatic wait_door(input string name, input int expected);
    int n;
    n = 0;
    while (bus_if.door === 1'b1 && n < 64) begin
      n++;
      step(3'b000, 4'b0000, 1'b0);
    end
    check(name, 16'(n), 16'(expected));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                car     hall     md    floor  door mreq mup  carlamp hall-lamp
    vecs[0]  = '{3'b000, 4'b0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0001};
    vecs[1]  = '{3'b000, 4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 3'b000, 4'b0001};
    vecs[2]  = '{3'b000, 4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 3'b000, 4'b0001};
    vecs[3]  = '{3'b000, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0001};
    vecs[4]  = '{3'b000, 4'b0000, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 3'b000, 4'b0001};
    vecs[5]  = '{3'b000, 4'b0000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0001};
    vecs[6]  = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[7]  = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[8]  = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[9]  = '{3'b000, 4'b0000, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[10] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[11] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[12] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[13] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[14] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[15] = '{3'b000, 4'b0000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000};
    vecs[16] = '{3'b000, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000};

    rst_n = 1'b0;
    bus_if.elevator_floor_button_pressed = 3'b000;
    bus_if.floor_button_pressed          = 4'b0000;
    bus_if.move_done                     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'(outs()), 16'({3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000}));
    @(negedge clk);
    rst_n = 1'b1;

    // V1 trip F1 -> F3 for the F3-down call, door timing, move_done ignored in door/idle (V6)
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].car, vecs[i].hall, vecs[i].md);
      check($sformatf("vec%0d", i), 16'(outs()),
            16'({vecs[i].exp_floor, vecs[i].exp_door, vecs[i].exp_mreq, vecs[i].exp_mup,
                 vecs[i].exp_car, vecs[i].exp_hall}));
    end

    // V3: at F3, both F2 hall calls -> down to F2, both clear, direction up afterwards
    step(3'b000, 4'b0110, 1'b0);
    check("v3_latch", 16'({bus_if.move_req, bus_if.floor_button_out}), 16'({1'b0, 4'b0110}));
    step(3'b000, 4'b0000, 1'b0);
    check("v3_move_down", 16'({bus_if.move_req, bus_if.move_up}), 16'(2'b10));
    step(3'b000, 4'b0000, 1'b1);
    check("v3_arrive_f2", 16'(bus_if.floor), 16'(3'b010));
    step(3'b000, 4'b0000, 1'b0);
    check("v3_door_clear", 16'({bus_if.door, bus_if.floor_button_out}), 16'({1'b1, 4'b0000}));
    wait_door("v3_door_len", 8);
    step(3'b101, 4'b0000, 1'b0);
    check("v3_car_latch", 16'(bus_if.elevator_button_out), 16'(3'b101));
    step(3'b000, 4'b0000, 1'b0);
    check("v3_dir_up", 16'({bus_if.move_req, bus_if.move_up}), 16'(2'b11));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v3_door_f3", 16'({bus_if.floor, bus_if.door, bus_if.elevator_button_out}),
          16'({3'b001, 1'b1, 3'b100}));
    wait_door("v3_door_f3_len", 8);
    step(3'b000, 4'b0000, 1'b0);
    check("v3_ret_down", 16'({bus_if.move_req, bus_if.move_up}), 16'(2'b10));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v3_pass_f2", 16'({bus_if.floor, bus_if.move_req, bus_if.move_up}), 16'({3'b010, 2'b10}));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v3_door_f1", 16'({bus_if.floor, bus_if.door, bus_if.elevator_button_out}),
          16'({3'b100, 1'b1, 3'b000}));
    wait_door("v3_door_f1_len", 8);

    // V2: car call at the current floor opens the door; re-presses hold it and never latch
    step(3'b100, 4'b0000, 1'b0);
    check("v2_latch", 16'({bus_if.door, bus_if.elevator_button_out}), 16'({1'b0, 3'b100}));
    step(3'b000, 4'b0000, 1'b0);
    check("v2_door", 16'({bus_if.door, bus_if.move_req, bus_if.elevator_button_out}),
          16'({1'b1, 1'b0, 3'b000}));
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 4'b0000, 1'b0);
      check($sformatf("v2_hold%0d", i),
            16'({bus_if.door, bus_if.move_req, bus_if.elevator_button_out}), 16'({1'b1, 1'b0, 3'b000}));
    end
    wait_door("v2_door_len", 8);
    check("v2_lamp_after", 16'(bus_if.elevator_button_out), 16'(3'b000));

    // V4: from F1 with car F3 and F2-down pending -> pass F2, stop F3, come back to F2
    step(3'b001, 4'b0100, 1'b0);
    check("v4_latch", 16'({bus_if.elevator_button_out, bus_if.floor_button_out}), 16'({3'b001, 4'b0100}));
    step(3'b000, 4'b0000, 1'b0);
    check("v4_up", 16'({bus_if.move_req, bus_if.move_up}), 16'(2'b11));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v4_pass_f2", 16'({bus_if.floor, bus_if.door, bus_if.move_req, bus_if.move_up, bus_if.floor_button_out}),
          16'({3'b010, 3'b011, 4'b0100}));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v4_stop_f3", 16'({bus_if.floor, bus_if.door, bus_if.elevator_button_out, bus_if.floor_button_out}),
          16'({3'b001, 1'b1, 3'b000, 4'b0100}));
    wait_door("v4_door_f3_len", 8);
    step(3'b000, 4'b0000, 1'b0);
    check("v4_down", 16'({bus_if.move_req, bus_if.move_up}), 16'(2'b10));
    step(3'b000, 4'b0000, 1'b1);
    step(3'b000, 4'b0000, 1'b0);
    check("v4_stop_f2", 16'({bus_if.floor, bus_if.door, bus_if.floor_button_out}),
          16'({3'b010, 1'b1, 4'b0000}));
    wait_door("v4_door_f2_len", 8);

    // V5: asynchronous reset in the middle of a move
    step(3'b001, 4'b0000, 1'b0);
    step(3'b000, 4'b0000, 1'b0);
    check("v5_moving", 16'({bus_if.move_req, bus_if.move_up, bus_if.elevator_button_out}),
          16'({2'b11, 3'b001}));
    #2;
    rst_n = 1'b0;
    #1;
    check("v5_async_reset", 16'(outs()), 16'({3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 4'b0000, 1'b0);
      check($sformatf("v5_no_resume%0d", i), 16'(outs()),
            16'({3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
